// File: rtl/inst_buffer_pkg.sv
// Shared fetch/dispatch definitions: packet typedefs, NOP encoding and memory latency.
`ifndef NOP
`define NOP 32'h0000_0013
`endif
`ifndef MEM_LATENCY_IN_CYCLES
`define MEM_LATENCY_IN_CYCLES 2
`endif

package inst_buffer_pkg;

  localparam logic [31:0] NOP_INST       = `NOP;
  localparam int unsigned MEM_LATENCY    = `MEM_LATENCY_IN_CYCLES;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } IF_IB_PACKET;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } IB_DP_PACKET;

  // Storage entry: occupancy is tracked by the count, so no per-entry valid bit.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } ib_entry_t;

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch-to-dispatch buffer signal bundle; master drives fetch/dispatch inputs, slave is the buffer.
interface inst_buffer_if #(
  parameter int unsigned IB_DEPTH = 8
) ();
  import inst_buffer_pkg::*;

  IF_IB_PACKET                 if_ib_packet;
  logic                        flush;
  logic                        dp_ready;
  IB_DP_PACKET                 ib_dp_packet;
  logic                        ib_full;
  logic [$clog2(IB_DEPTH):0]   ib_count;
  logic                        ib_overflow;

  modport master (
    output if_ib_packet, flush, dp_ready,
    input  ib_dp_packet, ib_full, ib_count, ib_overflow
  );

  modport slave (
    input  if_ib_packet, flush, dp_ready,
    output ib_dp_packet, ib_full, ib_count, ib_overflow
  );
endinterface

// File: rtl/inst_buffer.sv
// Circular first-word-fall-through instruction buffer between fetch and dispatch,
// with skid reserve for in-flight fetches and a sticky overflow flag.
`ifndef NOP
`define NOP 32'h0000_0013
`endif
`ifndef MEM_LATENCY_IN_CYCLES
`define MEM_LATENCY_IN_CYCLES 2
`endif

module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned IB_DEPTH = 8,
  parameter int unsigned IB_SKID  = `MEM_LATENCY_IN_CYCLES
) (
  input  logic          clock,
  input  logic          reset,
  inst_buffer_if.slave  ib
);

  localparam int unsigned PTR_W = $clog2(IB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  ib_entry_t          mem [IB_DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic               overflow;

  logic               not_empty;
  logic               at_capacity;
  logic               push;
  logic               pop;
  logic               drop;

  assign not_empty   = (count != '0);
  assign at_capacity = (count == CNT_W'(IB_DEPTH));
  assign pop         = ib.dp_ready && not_empty && !ib.flush;
  // A push at capacity is still taken when the head leaves in the same cycle.
  assign push        = ib.if_ib_packet.valid && (!at_capacity || pop) && !ib.flush;
  assign drop        = ib.if_ib_packet.valid && at_capacity && !pop && !ib.flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (ib.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[tail] <= '{inst: ib.if_ib_packet.inst,
                     PC:   ib.if_ib_packet.PC,
                     NPC:  ib.if_ib_packet.NPC};
    end
  end

  always_comb begin
    ib.ib_dp_packet      = '0;
    ib.ib_dp_packet.inst = NOP_INST;
    if (not_empty) begin
      ib.ib_dp_packet.valid = 1'b1;
      ib.ib_dp_packet.inst  = mem[head].inst;
      ib.ib_dp_packet.PC    = mem[head].PC;
      ib.ib_dp_packet.NPC   = mem[head].NPC;
    end
  end

  assign ib.ib_full     = (32'(count) + IB_SKID) >= IB_DEPTH;
  assign ib.ib_count    = count;
  assign ib.ib_overflow = overflow;

endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer (IB_DEPTH=8, IB_SKID=2).
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  logic clock;
  logic reset;
  int   tests_run;
  int   tests_failed;

  inst_buffer_if #(.IB_DEPTH(8)) ib ();

  inst_buffer #(.IB_DEPTH(8), .IB_SKID(2)) dut (
    .clock (clock),
    .reset (reset),
    .ib    (ib)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_push(input logic v, input logic [31:0] pc);
    ib.if_ib_packet.valid = v;
    ib.if_ib_packet.inst  = 32'h1000_0000 | pc;
    ib.if_ib_packet.PC    = pc;
    ib.if_ib_packet.NPC   = pc + 32'd4;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    ib.flush     = 1'b0;
    ib.dp_ready  = 1'b0;
    drive_push(1'b0, 32'h0);

    // reset state
    #12;
    check_eq("rst_count",    32'(ib.ib_count), 32'd0);
    check_eq("rst_valid",    32'(ib.ib_dp_packet.valid), 32'd0);
    check_eq("rst_full",     32'(ib.ib_full), 32'd0);
    check_eq("rst_overflow", 32'(ib.ib_overflow), 32'd0);
    check_eq("rst_nop",      ib.ib_dp_packet.inst, NOP_INST);
    reset = 1'b1;

    // in-order delivery; push is not visible in its own cycle
    drive_push(1'b1, 32'h0);
    #1;
    check_eq("no_bypass_valid", 32'(ib.ib_dp_packet.valid), 32'd0);
    tick();
    check_eq("first_visible_pc", ib.ib_dp_packet.PC, 32'h0);
    drive_push(1'b1, 32'h4); tick();
    drive_push(1'b1, 32'h8); tick();
    drive_push(1'b0, 32'h0);
    check_eq("order_count3", 32'(ib.ib_count), 32'd3);
    check_eq("order_head",   ib.ib_dp_packet.PC, 32'h0);
    check_eq("order_npc",    ib.ib_dp_packet.NPC, 32'h4);
    ib.dp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("order_pc",   ib.ib_dp_packet.PC, 32'(4 * i));
      check_eq("order_inst", ib.ib_dp_packet.inst, 32'h1000_0000 | 32'(4 * i));
      tick();
    end
    check_eq("drained_valid", 32'(ib.ib_dp_packet.valid), 32'd0);
    check_eq("drained_nop",   ib.ib_dp_packet.inst, NOP_INST);
    check_eq("drained_pc",    ib.ib_dp_packet.PC, 32'h0);
    // empty with dp_ready held: nothing pops, count stays 0
    tick();
    check_eq("empty_pop_count", 32'(ib.ib_count), 32'd0);
    ib.dp_ready = 1'b0;

    // skid threshold and overflow
    for (int k = 0; k < 8; k++) begin
      drive_push(1'b1, 32'h100 + 32'(4 * k));
      tick();
      check_eq("fill_count", 32'(ib.ib_count), 32'(k + 1));
      check_eq("fill_full",  32'(ib.ib_full), (k + 1 >= 6) ? 32'd1 : 32'd0);
    end
    check_eq("pre_ovf_flag", 32'(ib.ib_overflow), 32'd0);
    drive_push(1'b1, 32'h200);
    tick();
    check_eq("ovf_count", 32'(ib.ib_count), 32'd8);
    check_eq("ovf_flag",  32'(ib.ib_overflow), 32'd1);
    check_eq("ovf_head",  ib.ib_dp_packet.PC, 32'h100);

    // simultaneous push and pop at capacity
    drive_push(1'b1, 32'h40);
    ib.dp_ready = 1'b1;
    tick();
    drive_push(1'b0, 32'h0);
    check_eq("fullpp_count",    32'(ib.ib_count), 32'd8);
    check_eq("fullpp_overflow", 32'(ib.ib_overflow), 32'd1);
    for (int k = 0; k < 8; k++) begin
      check_eq("fullpp_pc", ib.ib_dp_packet.PC, (k == 7) ? 32'h40 : 32'h104 + 32'(4 * k));
      tick();
    end
    check_eq("fullpp_empty", 32'(ib.ib_count), 32'd0);
    ib.dp_ready = 1'b0;

    // asynchronous reset mid-stream, between clock edges
    for (int k = 0; k < 3; k++) begin
      drive_push(1'b1, 32'h600 + 32'(4 * k));
      tick();
    end
    check_eq("pre_arst_count", 32'(ib.ib_count), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_count",    32'(ib.ib_count), 32'd0);
    check_eq("arst_valid",    32'(ib.ib_dp_packet.valid), 32'd0);
    check_eq("arst_full",     32'(ib.ib_full), 32'd0);
    check_eq("arst_overflow", 32'(ib.ib_overflow), 32'd0);
    drive_push(1'b0, 32'h0);
    #2;
    reset = 1'b1;
    tick();

    // wrap-around streaming
    ib.dp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_push(1'b1, 32'h300 + 32'(4 * i));
      tick();
      check_eq("stream_pc",    ib.ib_dp_packet.PC, 32'h300 + 32'(4 * i));
      check_eq("stream_count", 32'(ib.ib_count), 32'd1);
    end
    drive_push(1'b0, 32'h0);
    tick();
    check_eq("stream_empty",    32'(ib.ib_count), 32'd0);
    check_eq("stream_overflow", 32'(ib.ib_overflow), 32'd0);
    ib.dp_ready = 1'b0;

    // flush beats push and pop
    for (int k = 0; k < 5; k++) begin
      drive_push(1'b1, 32'h400 + 32'(4 * k));
      tick();
    end
    check_eq("preflush_count", 32'(ib.ib_count), 32'd5);
    drive_push(1'b1, 32'hDEAD0);
    ib.flush    = 1'b1;
    ib.dp_ready = 1'b1;
    #1;
    check_eq("flush_cycle_pc",    ib.ib_dp_packet.PC, 32'h400);
    check_eq("flush_cycle_valid", 32'(ib.ib_dp_packet.valid), 32'd1);
    tick();
    ib.flush    = 1'b0;
    ib.dp_ready = 1'b0;
    drive_push(1'b0, 32'h0);
    check_eq("flush_count", 32'(ib.ib_count), 32'd0);
    check_eq("flush_valid", 32'(ib.ib_dp_packet.valid), 32'd0);
    tick();
    check_eq("postflush_count", 32'(ib.ib_count), 32'd0);
    drive_push(1'b1, 32'h500);
    tick();
    drive_push(1'b0, 32'h0);
    check_eq("postflush_pc",    ib.ib_dp_packet.PC, 32'h500);
    check_eq("postflush_count", 32'(ib.ib_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
